load_store_unit: RTL and testbench

//  Multi-cycle load/store stage that sits directly downstream of the register file.
//  It consumes the base address (datA_out) and the store data (datB_out) and

---
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store stage: computes base+imm, runs one req/ack memory transaction, writes loaded byte back to the reg file.
// Latency: done k+1 cycles after start (k = REQ cycles); busy stalls upstream; start while busy is dropped.
module load_store_unit #(
   parameter int pw      = 3,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          is_load,
   input  logic [7:0]    base,
   input  logic [2:0]    imm,
   input  logic [7:0]    st_data,
   input  logic [pw-1:0] dst_addr,
   output logic          mem_req,
   output logic          mem_we,
   output logic [7:0]    mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic          mem_ack,
   input  logic [7:0]    mem_rdata,
   output logic          rf_wr_en,
   output logic [pw-1:0] rf_wr_addr,
   output logic [7:0]    rf_dat,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic          load_q, load_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [pw-1:0] dst_q, dst_d;
   logic [7:0]    rdata_q, rdata_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          abort_q, abort_d;

   logic [7:0]    eff_addr;

   assign eff_addr = base + {{5{imm[2]}}, imm};

   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dst_d   = dst_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load_d  = is_load;
               addr_d  = eff_addr;
               wdata_d = st_data;
               dst_d   = dst_addr;
               cnt_d   = 8'd0;
               abort_d = 1'b0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // An ack on the final allowed cycle still completes normally.
            if (mem_ack) begin
               rdata_d = mem_rdata;
               state_d = load_q ? S_WB : S_FIN;
            end else if (cnt_q == CNT_LAST) begin
               abort_d = 1'b1;
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         load_q  <= 1'b0;
         addr_q  <= 8'd0;
         wdata_q <= 8'd0;
         dst_q   <= '0;
         rdata_q <= 8'd0;
         cnt_q   <= 8'd0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dst_q   <= dst_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
      end
   end

   // Outputs decode straight from state so async reset clears them at once.
   assign mem_req    = (state_q == S_REQ);
   assign mem_we     = mem_req & ~load_q;
   assign mem_addr   = mem_req ? addr_q  : 8'd0;
   assign mem_wdata  = mem_req ? wdata_q : 8'd0;
   assign rf_wr_en   = (state_q == S_WB);
   assign rf_wr_addr = rf_wr_en ? dst_q   : '0;
   assign rf_dat     = rf_wr_en ? rdata_q : 8'd0;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_WB) | (state_q == S_FIN);
   assign err        = (state_q == S_FIN) & abort_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: load, store, wrap, timeout, busy-start, mid-flight reset.
module tb_load_store_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       is_load;
   logic [7:0] base;
   logic [2:0] imm;
   logic [7:0] st_data;
   logic [2:0] dst_addr;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_ack;
   logic [7:0] mem_rdata;
   logic       rf_wr_en;
   logic [2:0] rf_wr_addr;
   logic [7:0] rf_dat;
   logic       busy;
   logic       done;
   logic       err;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   load_store_unit #(.pw(3), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .start(start), .is_load(is_load),
      .base(base), .imm(imm), .st_data(st_data), .dst_addr(dst_addr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat(rf_dat),
      .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic ld, input logic [7:0] b, input logic [2:0] im,
                         input logic [7:0] sd, input logic [2:0] dst);
      start = 1'b1; is_load = ld; base = b; imm = im; st_data = sd; dst_addr = dst;
      step();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; is_load = 1'b0; base = 8'd0; imm = 3'd0;
      st_data = 8'd0; dst_addr = 3'd0; mem_ack = 1'b0; mem_rdata = 8'd0;
      step();
      chk("rst_mem_req", {7'd0, mem_req}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_rf_wr_en", {7'd0, rf_wr_en}, 8'd0);
      chk("rst_mem_addr", mem_addr, 8'h00);
      reset = 1'b1;
      step();

      // ack in IDLE must not start anything
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("idle_ack_busy", {7'd0, busy}, 8'd0);

      // 1: load, ack in third REQ cycle
      launch(1'b1, 8'h10, 3'd2, 8'h00, 3'd3);
      chk("ld_req_c1", {7'd0, mem_req}, 8'd1);
      chk("ld_addr", mem_addr, 8'h12);
      chk("ld_we", {7'd0, mem_we}, 8'd0);
      chk("ld_busy", {7'd0, busy}, 8'd1);
      step();
      chk("ld_req_c2", {7'd0, mem_req}, 8'd1);
      step();
      chk("ld_req_c3", {7'd0, mem_req}, 8'd1);
      mem_ack = 1'b1; mem_rdata = 8'hA5;
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      chk("ld_wb_req", {7'd0, mem_req}, 8'd0);
      chk("ld_wr_en", {7'd0, rf_wr_en}, 8'd1);
      chk("ld_wr_addr", {5'd0, rf_wr_addr}, 8'd3);
      chk("ld_rf_dat", rf_dat, 8'hA5);
      chk("ld_done", {7'd0, done}, 8'd1);
      chk("ld_err", {7'd0, err}, 8'd0);
      step();
      chk("ld_idle_busy", {7'd0, busy}, 8'd0);
      chk("ld_idle_done", {7'd0, done}, 8'd0);
      chk("ld_idle_wr_en", {7'd0, rf_wr_en}, 8'd0);

      // 2: store, immediate ack, done at cycle 2
      launch(1'b0, 8'h01, 3'b100, 8'h5C, 3'd6);
      chk("st_addr", mem_addr, 8'hFD);
      chk("st_we", {7'd0, mem_we}, 8'd1);
      chk("st_wdata", mem_wdata, 8'h5C);
      mem_ack = 1'b1; mem_rdata = 8'h77;
      step();
      mem_ack = 1'b0;
      chk("st_done", {7'd0, done}, 8'd1);
      chk("st_wr_en", {7'd0, rf_wr_en}, 8'd0);
      chk("st_err", {7'd0, err}, 8'd0);
      step();
      chk("st_idle_busy", {7'd0, busy}, 8'd0);

      // 3: address wrap
      launch(1'b1, 8'hFF, 3'd1, 8'h00, 3'd1);
      chk("wrap_addr", mem_addr, 8'h00);
      mem_ack = 1'b1; mem_rdata = 8'h11;
      step();
      mem_ack = 1'b0;
      chk("wrap_rf_dat", rf_dat, 8'h11);
      step();

      // 4a: timeout, ack never comes
      launch(1'b1, 8'h30, 3'd0, 8'h00, 3'd2);
      for (int i = 1; i <= 15; i++) begin
         chk($sformatf("to_req_c%0d", i), {7'd0, mem_req}, 8'd1);
         step();
      end
      chk("to_req_dropped", {7'd0, mem_req}, 8'd0);
      chk("to_done", {7'd0, done}, 8'd1);
      chk("to_err", {7'd0, err}, 8'd1);
      chk("to_wr_en", {7'd0, rf_wr_en}, 8'd0);
      step();
      chk("to_idle_busy", {7'd0, busy}, 8'd0);
      chk("to_idle_err", {7'd0, err}, 8'd0);

      // 4b: ack on the 15th REQ cycle wins over timeout
      launch(1'b1, 8'h30, 3'd0, 8'h00, 3'd5);
      for (int i = 1; i <= 14; i++) step();
      chk("tob_req_c15", {7'd0, mem_req}, 8'd1);
      mem_ack = 1'b1; mem_rdata = 8'h3C;
      step();
      mem_ack = 1'b0;
      chk("tob_done", {7'd0, done}, 8'd1);
      chk("tob_err", {7'd0, err}, 8'd0);
      chk("tob_wr_en", {7'd0, rf_wr_en}, 8'd1);
      chk("tob_rf_dat", rf_dat, 8'h3C);
      step();

      // 5: start while busy is ignored
      launch(1'b0, 8'h20, 3'd0, 8'h99, 3'd0);
      start = 1'b1; base = 8'h40; st_data = 8'h66;
      step();
      start = 1'b0;
      chk("busy_start_addr", mem_addr, 8'h20);
      chk("busy_start_wdata", mem_wdata, 8'h99);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("busy_start_done", {7'd0, done}, 8'd1);
      step();
      chk("busy_start_idle", {7'd0, busy}, 8'd0);
      step();
      chk("busy_start_no_req", {7'd0, mem_req}, 8'd0);

      // 6: async reset in REQ
      launch(1'b1, 8'h50, 3'd3, 8'h00, 3'd4);
      chk("rs_req_before", {7'd0, mem_req}, 8'd1);
      reset = 1'b0;
      #1;
      chk("rs_req_async", {7'd0, mem_req}, 8'd0);
      chk("rs_busy_async", {7'd0, busy}, 8'd0);
      step();
      reset = 1'b1;
      step();
      chk("rs_idle_busy", {7'd0, busy}, 8'd0);
      chk("rs_no_wb", {7'd0, rf_wr_en}, 8'd0);
      launch(1'b1, 8'h50, 3'd3, 8'h00, 3'd4);
      chk("rs_next_addr", mem_addr, 8'h53);
      mem_ack = 1'b1; mem_rdata = 8'hC3;
      step();
      mem_ack = 1'b0;
      chk("rs_next_wr_en", {7'd0, rf_wr_en}, 8'd1);
      chk("rs_next_wr_addr", {5'd0, rf_wr_addr}, 8'd4);
      chk("rs_next_rf_dat", rf_dat, 8'hC3);
      step();
      chk("rs_next_idle", {7'd0, busy}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
